// File: rtl/booth_r4_mult.sv
// rtl/booth_r4_mult.sv - radix-4 Booth sequential multiplier, TAMANO-bit operands, START/DONE handshake
// Optional macro SIGNED_MODE_EN adds the SIGNED port; without it operands are always two's complement.
module booth_r4_mult #(
    parameter int TAMANO = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
`ifdef SIGNED_MODE_EN
    input  logic                  SIGNED,
`endif
    input  logic [TAMANO-1:0]     A,
    input  logic [TAMANO-1:0]     B,
    output logic [2*TAMANO-1:0]   S,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int W  = TAMANO + 2;
    localparam int N  = W / 2;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CALC
    } state_t;

    state_t              state_q;
    logic [W-1:0]        m_q;
    logic [W:0]          hi_q;
    logic [W-1:0]        lo_q;
    logic                qm1_q;
    logic [CW-1:0]       cnt_q;
    logic [2*TAMANO-1:0] s_q;
    logic                busy_q;
    logic                done_q;

    logic                sgn;
    logic [W-1:0]        a_ext;
    logic [W-1:0]        b_ext;
    logic [W:0]          m_ext;
    logic [W:0]          addend;
    logic [W:0]          sum_d;
    logic [W:0]          hi_d;
    logic [W-1:0]        lo_d;
    logic                qm1_d;
    logic [2:0]          sel;

`ifdef SIGNED_MODE_EN
    assign sgn = SIGNED;
`else
    assign sgn = 1'b1;
`endif

    // Two guard bits keep zero-extended unsigned operands positive in the signed Booth recoding.
    assign a_ext = {{2{sgn & A[TAMANO-1]}}, A};
    assign b_ext = {{2{sgn & B[TAMANO-1]}}, B};
    assign m_ext = {m_q[W-1], m_q};
    assign sel   = {lo_q[1:0], qm1_q};

    always_comb begin
        addend = '0;
        unique case (sel)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end

    assign sum_d = hi_q + addend;
    assign hi_d  = {sum_d[W], sum_d[W], sum_d[W:2]};
    assign lo_d  = {sum_d[1:0], lo_q[W-1:2]};
    assign qm1_d = lo_q[1];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        m_q     <= a_ext;
                        hi_q    <= '0;
                        lo_q    <= b_ext;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        // Product is the low 2*TAMANO bits of the final {HI, LO}.
                        s_q     <= {hi_d[TAMANO-3:0], lo_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign S    = s_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// tb/tb_booth_r4_mult.sv - self-checking bench for booth_r4_mult (TAMANO=8 and TAMANO=16 instances)
module tb_booth_r4_mult;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] s8;
    logic        busy8, done8;
    logic [15:0] a16, b16;
    logic [31:0] s16;
    logic        busy16, done16;
`ifdef SIGNED_MODE_EN
    logic        sg8, sg16;
    localparam bit HAS_MODE = 1'b1;
`else
    localparam bit HAS_MODE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    booth_r4_mult #(.TAMANO(8)) u8 (
        .CLOCK (clk),
        .RESET (rst_n),
        .START (start8),
`ifdef SIGNED_MODE_EN
        .SIGNED(sg8),
`endif
        .A     (a8),
        .B     (b8),
        .S     (s8),
        .BUSY  (busy8),
        .DONE  (done8)
    );

    booth_r4_mult #(.TAMANO(16)) u16 (
        .CLOCK (clk),
        .RESET (rst_n),
        .START (start16),
`ifdef SIGNED_MODE_EN
        .SIGNED(sg16),
`endif
        .A     (a16),
        .B     (b16),
        .S     (s16),
        .BUSY  (busy16),
        .DONE  (done16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sg;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input bit sg);
        longint x, y;
        bit eff;
        eff = HAS_MODE ? sg : 1'b1;
        x = longint'(a);
        y = longint'(b);
        if (eff && a[w-1]) x = x - (longint'(1) << w);
        if (eff && b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic do_op(input bit big, input logic [15:0] a, input logic [15:0] b, input bit sg,
                         output logic [31:0] s, output int lat, output bit got,
                         output logic busy_s, output logic busy_d, output logic done_after);
        @(negedge clk);
        if (big) begin
            a16 = a; b16 = b; start16 = 1'b1;
`ifdef SIGNED_MODE_EN
            sg16 = sg;
`endif
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
`ifdef SIGNED_MODE_EN
            sg8 = sg;
`endif
        end
        @(posedge clk);
        lat = 1;
        got = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        busy_s = big ? busy16 : busy8;
        for (int e = 0; e < 40; e++) begin
            if (big ? done16 : done8) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        s = big ? s16 : {16'h0, s8};
        busy_d = big ? busy16 : busy8;
        @(negedge clk);
        done_after = big ? done16 : done8;
    endtask

    task automatic wait_done8(input bit churn, output int lat, output bit got);
        lat = 1;
        got = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (churn) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int          lat;
        bit          got;
        logic        busy_s, busy_d, done_after;
        bit          saw_done;
        logic [15:0] ra, rb;
        bit          rsg;

        rst_n = 1'b0;
        start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
`ifdef SIGNED_MODE_EN
        sg8 = 1'b0; sg16 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset S8", s8, 0);
        check("reset BUSY8", busy8, 0);
        check("reset DONE8", done8, 0);
        check("reset S16", s16, 0);
        check("reset BUSY16", busy16, 0);
        rst_n = 1'b1;

        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 16'h0000});
        vecs.push_back('{8'hFF, 8'h02, 1'b1, 16'hFFFE});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h05, 8'hFD, 1'b1, 16'hFFF1});
`ifdef SIGNED_MODE_EN
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'hFF, 8'h02, 1'b0, 16'h01FE});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 16'h0000});
`endif
        foreach (vecs[i]) begin
            do_op(1'b0, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].sg, s, lat, got,
                  busy_s, busy_d, done_after);
            check($sformatf("vec%0d done seen", i), 64'(got), 1);
            check($sformatf("vec%0d S", i), 64'(s), 64'(vecs[i].exp));
            check($sformatf("vec%0d latency", i), 64'(lat), 6);
            check($sformatf("vec%0d busy after start", i), 64'(busy_s), 1);
            check($sformatf("vec%0d busy in done cycle", i), 64'(busy_d), 0);
            check($sformatf("vec%0d done single pulse", i), 64'(done_after), 0);
            check($sformatf("vec%0d S held", i), 64'(s8), 64'(vecs[i].exp));
        end

        // START held high, operands churning; second op accepted from the DONE cycle.
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        wait_done8(1'b1, lat, got);
        check("b2b1 done seen", 64'(got), 1);
        check("b2b1 latency", 64'(lat), 6);
        check("b2b1 S", 64'(s8), 63);
        check("b2b1 busy in done", 64'(busy8), 0);
        a8 = 8'd11; b8 = 8'd13;
        @(posedge clk);
        wait_done8(1'b1, lat, got);
        start8 = 1'b0;
        check("b2b2 done seen", 64'(got), 1);
        check("b2b2 latency", 64'(lat), 6);
        check("b2b2 S", 64'(s8), 143);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle after", 64'(busy8), 0);
        check("b2b S held", 64'(s8), 143);

        // Reset during the third CALC step of 100x100.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort S", 64'(s8), 0);
        check("abort BUSY", 64'(busy8), 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        check("abort no DONE", 64'(saw_done), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        check("abort no DONE after release", 64'(saw_done), 0);
        do_op(1'b0, 16'd3, 16'd5, 1'b1, s, lat, got, busy_s, busy_d, done_after);
        check("post-abort done seen", 64'(got), 1);
        check("post-abort S", 64'(s), 15);
        check("post-abort latency", 64'(lat), 6);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rsg = 1'($urandom);
            do_op(1'b0, ra, rb, rsg, s, lat, got, busy_s, busy_d, done_after);
            check("rand8 S", 64'(s), ref_mul(64'(ra), 64'(rb), 8, rsg));
            check("rand8 latency", 64'(lat), 6);
        end

        for (int md = 0; md < 2; md++) begin
            if (md == 0 && !HAS_MODE) continue;
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (i == 0) begin ra = 16'h8000; rb = 16'h8000; end
                if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; end
                do_op(1'b1, ra, rb, md[0], s, lat, got, busy_s, busy_d, done_after);
                check("rand16 done seen", 64'(got), 1);
                check("rand16 S", 64'(s), ref_mul(64'(ra), 64'(rb), 16, md[0]));
                check("rand16 latency", 64'(lat), 10);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_r4_mult.md
# booth_r4_mult

Parametrised radix-4 Booth sequential multiplier combining datapath and controller in one block, succeeding the fixed 8-bit shift-and-add datapath. Computes a full-width product of two TAMANO-bit operands in TAMANO/2+1 iteration cycles. Supports per-operation signed or unsigned operands and a START/DONE handshake. Sits between the operand-capture logic and the result consumer in the multiplier subsystem.

## Interface
- TAMANO, 8, operand width; even, ≥4.
- CLOCK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START (present only with macro, see Configuration).
- A  input  TAMANO  multiplicand; sampled with START.
- B  input  TAMANO  multiplier; sampled with START.
- S  output  2*TAMANO  product; held until the next completion or reset.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; S valid.

## Operation
- Internal width W = TAMANO+2. On accept, A and B are extended to W bits: sign-extended if SIGNED=1, zero-extended if SIGNED=0.
- Registers:
  - M (W bits) holds extended A.
  - HI accumulator (W+1 bits) cleared.
  - LO shifter (W bits) holds extended B.
  - X bit q₋₁ cleared.
  - Step counter cleared.
- States:
  - IDLE → CALC on START=1.
  - CALC → CALC while counter < N−1, where N = W/2.
  - CALC → IDLE on the last step.
- Each CALC step examines {LO[1], LO[0], q₋₁}:
  - 000 or 111 → +0
  - 001 or 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 or 110 → −M
- M is sign-extended to W+1 bits before the add/sub into HI.
- After the add, {HI, LO, q₋₁} shifts arithmetic-right by 2. q₋₁ takes old LO[1]; LO[W-1:W-2] take the sum's low two bits.
- On the last step, S ← the low 2*TAMANO bits of the shifted {HI, LO}. The result is exact for both modes.
- START while BUSY=1 is ignored; operand inputs may change freely.

## Timing
- Reset values:
  - S=0, BUSY=0, DONE=0, state IDLE.
  - All internal registers 0.
- START=1 at edge k:
  - BUSY=1 from after edge k.
  - Steps execute on edges k+1 … k+N.
  - At edge k+N: S updates, DONE=1 for exactly that one cycle, BUSY=0.
- Latency: N+1 edges from the START sample to DONE. For TAMANO=8, N=5 and latency is 6.
- Back-to-back: START=1 during the DONE cycle is accepted at the next edge. Throughput is one product per N+1 cycles.
- Reset asserted mid-operation aborts immediately: S=0, no DONE pulse. After release, the block returns to IDLE.
- S does not change between completions.

## Configuration
- SIGNED_MODE_EN defined:
  - SIGNED port present; mode is selectable per operation.
- SIGNED_MODE_EN undefined:
  - SIGNED port absent.
  - Operands are always two's complement (internal signed flag tied to 1).
  - Timing is identical.

## Test plan
- TAMANO=8, SIGNED=0, A=255, B=255, START → after 6 edges DONE=1 and S=0xFE01. BUSY low in the DONE cycle.
- TAMANO=8, SIGNED=1:
  - A=−128, B=−128 → S=0x4000.
  - A=−128, B=127 → S=0xC080.
  - A=0, B=−1 → S=0x0000.
- START held high across a whole operation with A/B changing mid-operation → result uses the operands from the first sample. The next operation starts in the DONE cycle and completes 6 edges later.
- RESET low at the 3rd CALC edge of 100×100 → S=0, BUSY=0, no DONE. A following 3×5 gives S=15.
- TAMANO=16, 1000 random operand pairs in each mode → S matches the reference product; every DONE arrives exactly 10 edges after its START.
- Compiled without SIGNED_MODE_EN, TAMANO=8, A=0xFF, B=0x02 → S=0xFFFE (−2).
